// File: rtl/sysbus_port_arbiter.sv
// Multi-port sysbus arbiter: grants one client at a time and runs its address
// beat, then either a write burst or a read-response burst, before
// re-arbitrating.
// Optional build macro SYSBUS_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration. When it is undefined, the lowest-numbered valid port wins.
module sysbus_port_arbiter #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TAG_WIDTH   = 13,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned BURST_BEATS = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_req_valid,
    input  logic [NUM_PORTS-1:0]            port_req_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_req_addr,
    output logic [NUM_PORTS-1:0]            port_req_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]            port_wdata_ready,
    output logic [NUM_PORTS-1:0]            port_resp_valid,
    output logic [DATA_WIDTH-1:0]           port_resp_data,
    output logic                            reqcyc,
    output logic [DATA_WIDTH-1:0]           req,
    output logic [TAG_WIDTH-1:0]            reqtag,
    input  logic                            reqack,
    input  logic                            respcyc,
    input  logic [DATA_WIDTH-1:0]           resp,
    input  logic [TAG_WIDTH-1:0]            resptag,
    output logic                            respack
);

    localparam int unsigned PORT_BITS = $clog2(NUM_PORTS);
    localparam int unsigned CNT_WIDTH = $clog2(BURST_BEATS) + 1;

    typedef enum logic [1:0] {StIdle, StAddr, StWdata, StResp} state_e;

    state_e                 state_q, state_d;
    logic [PORT_BITS-1:0]   winner_q, winner_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PORT_BITS-1:0]   pick;
    logic [TAG_WIDTH-1:0]   bus_tag;
    logic                   last_beat;
    logic                   tag_match;

    // Only the port-index bits of the response tag are meaningful here.
    logic unused_resptag;
    assign unused_resptag = ^resptag;

    assign last_beat = (cnt_q == CNT_WIDTH'(BURST_BEATS - 1));
    assign tag_match = (resptag[PORT_BITS-1:0] == winner_q);

`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
    logic [PORT_BITS-1:0] rr_q, rr_d;
    logic                 found;
    logic [PORT_BITS-1:0] idx;

    // Round-robin pick: first valid port at or after the pointer.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = PORT_BITS'((32'(rr_q) + i) % NUM_PORTS);
            if (!found && port_req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: scanning downwards leaves the lowest valid port.
    always_comb begin
        pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_req_valid[i]) pick = PORT_BITS'(i);
        end
    end
`endif

    // Tag carries the write flag in the MSB and the granted port in the LSBs.
    always_comb begin
        bus_tag                  = '0;
        bus_tag[TAG_WIDTH-1]     = write_q;
        bus_tag[PORT_BITS-1:0]   = winner_q;
    end

    // State, grant and beat-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            winner_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
            rr_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // Next-state and bus/port outputs; everything is forced quiet during reset.
    always_comb begin
        state_d          = state_q;
        winner_d         = winner_q;
        write_d          = write_q;
        addr_d           = addr_q;
        cnt_d            = cnt_q;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        rr_d             = rr_q;
`endif
        reqcyc           = 1'b0;
        req              = '0;
        reqtag           = '0;
        respack          = respcyc;
        port_req_ready   = '0;
        port_wdata_ready = '0;
        port_resp_valid  = '0;
        port_resp_data   = '0;

        unique case (state_q)
            StIdle: begin
                if (|port_req_valid) begin
                    winner_d = pick;
                    write_d  = port_req_write[pick];
                    addr_d   = port_req_addr[32'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    state_d  = StAddr;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
                    rr_d     = PORT_BITS'((32'(pick) + 32'd1) % NUM_PORTS);
`endif
                end
            end
            StAddr: begin
                reqcyc = 1'b1;
                req    = addr_q;
                reqtag = bus_tag;
                if (reqack) begin
                    port_req_ready[winner_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = write_q ? StWdata : StResp;
                end
            end
            StWdata: begin
                reqcyc = 1'b1;
                req    = port_wdata[32'(winner_q)*DATA_WIDTH +: DATA_WIDTH];
                reqtag = bus_tag;
                if (reqack) begin
                    port_wdata_ready[winner_q] = 1'b1;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last_beat) state_d = StIdle;
                end
            end
            StResp: begin
                // Beats for other tags are acked and dropped.
                if (respcyc && tag_match) begin
                    port_resp_valid[winner_q] = 1'b1;
                    port_resp_data = resp;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last_beat) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reset) begin
            reqcyc           = 1'b0;
            req              = '0;
            reqtag           = '0;
            respack          = 1'b0;
            port_req_ready   = '0;
            port_wdata_ready = '0;
            port_resp_valid  = '0;
            port_resp_data   = '0;
        end
    end

endmodule

// File: tb/tb_sysbus_port_arbiter.sv
// Self-checking bench for sysbus_port_arbiter (default parameters).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed pulse counts and tag values.
module tb_sysbus_port_arbiter;

    localparam int NP = 2;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int BEATS = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   port_req_valid, port_req_write;
    logic [NP*DW-1:0] port_req_addr, port_wdata;
    logic [NP-1:0]   port_req_ready, port_wdata_ready, port_resp_valid;
    logic [DW-1:0]   port_resp_data;
    logic            reqcyc, reqack, respcyc, respack;
    logic [DW-1:0]   req, resp;
    logic [TW-1:0]   reqtag, resptag;

    sysbus_port_arbiter dut (
        .clk(clk), .reset(reset),
        .port_req_valid(port_req_valid), .port_req_write(port_req_write),
        .port_req_addr(port_req_addr), .port_req_ready(port_req_ready),
        .port_wdata(port_wdata), .port_wdata_ready(port_wdata_ready),
        .port_resp_valid(port_resp_valid), .port_resp_data(port_resp_data),
        .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
        .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state: busy with a grant, address accepted, beats done.
    bit        m_busy, m_acc, m_wr;
    int        m_port, m_beats, m_ptr;
    logic [DW-1:0] m_addr;
    bit        n_busy, n_acc, n_wr;
    int        n_port, n_beats, n_ptr;
    logic [DW-1:0] n_addr;

    logic          e_reqcyc, e_respack;
    logic [DW-1:0] e_req, e_rdata;
    logic [TW-1:0] e_tag;
    logic [NP-1:0] e_rdy, e_wrdy, e_rv;

    // Observed pulse statistics, pinned against literals by the directed tests.
    int resp_cnt[NP], wrdy_cnt[NP], rdy_cnt[NP];
    int req_beats = 0, ack_cnt = 0;
    int grants[$];
    logic [TW-1:0] last_tag = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_acc <= 0; m_wr <= 0; m_port <= 0;
            m_beats <= 0; m_ptr <= 0; m_addr <= '0;
        end else begin
            m_busy <= n_busy; m_acc <= n_acc; m_wr <= n_wr; m_port <= n_port;
            m_beats <= n_beats; m_ptr <= n_ptr; m_addr <= n_addr;
        end
    end

    always @(negedge clk) begin
        int w;
        bit found;
        e_reqcyc = 0; e_req = '0; e_tag = '0; e_respack = 0;
        e_rdy = '0; e_wrdy = '0; e_rv = '0; e_rdata = '0;
        n_busy = m_busy; n_acc = m_acc; n_wr = m_wr; n_port = m_port;
        n_beats = m_beats; n_ptr = m_ptr; n_addr = m_addr;
        if (reset) begin
            n_busy = 0; n_acc = 0; n_wr = 0; n_port = 0; n_beats = 0; n_ptr = 0;
            n_addr = '0;
        end else begin
            e_respack = respcyc;
            if (!m_busy) begin
                if (port_req_valid != 0) begin
                    found = 0; w = 0;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
                    for (int k = 0; k < NP; k++)
                        if (!found && port_req_valid[(m_ptr + k) % NP]) begin
                            w = (m_ptr + k) % NP; found = 1;
                        end
`else
                    while (!port_req_valid[w]) w++;
`endif
                    n_busy = 1; n_acc = 0; n_port = w; n_wr = port_req_write[w];
                    n_addr = port_req_addr[w*DW +: DW];
                    n_ptr = (w + 1) % NP;
                end
            end else if (!m_acc) begin
                e_reqcyc = 1; e_req = m_addr; e_tag = TW'(m_wr * 4096 + m_port);
                if (reqack) begin
                    e_rdy[m_port] = 1; n_acc = 1; n_beats = 0;
                end
            end else if (m_wr) begin
                e_reqcyc = 1; e_req = port_wdata[m_port*DW +: DW];
                e_tag = TW'(m_wr * 4096 + m_port);
                if (reqack) begin
                    e_wrdy[m_port] = 1; n_beats = m_beats + 1;
                    if (n_beats == BEATS) n_busy = 0;
                end
            end else begin
                if (respcyc && (resptag % NP) == m_port) begin
                    e_rv[m_port] = 1; e_rdata = resp; n_beats = m_beats + 1;
                    if (n_beats == BEATS) n_busy = 0;
                end
            end
        end
        check("reqcyc", reqcyc, e_reqcyc);
        check("req", req, e_req);
        check("reqtag", reqtag, e_tag);
        check("respack", respack, e_respack);
        check("port_req_ready", port_req_ready, e_rdy);
        check("port_wdata_ready", port_wdata_ready, e_wrdy);
        check("port_resp_valid", port_resp_valid, e_rv);
        check("port_resp_data", port_resp_data, e_rdata);
        for (int p = 0; p < NP; p++) begin
            if (port_resp_valid[p]) resp_cnt[p]++;
            if (port_wdata_ready[p]) wrdy_cnt[p]++;
            if (port_req_ready[p]) rdy_cnt[p]++;
        end
        if (reqcyc && reqack) req_beats++;
        if (respack) ack_cnt++;
        if (port_req_ready != 0) begin
            grants.push_back(int'(reqtag[0]));
            last_tag = reqtag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reqcyc();
        int n = 0;
        while (!reqcyc && n < 20) begin tick(); n++; end
        check("wait_reqcyc", reqcyc, 1'b1);
    endtask

    initial begin
        int r, a, b, wc, n;
        int exp_grants[4];
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int r, a, b, wc, n;
        int exp_grants[4];
        reset = 1; port_req_valid = 2'b11; port_req_write = 2'b11;
        port_req_addr = '1; port_wdata = '1; reqack = 1; respcyc = 1;
        resp = '1; resptag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_reqcyc", reqcyc, 0);
        check("rst_respack", respack, 0);
        check("rst_req", req, 0);
        check("rst_reqtag", reqtag, 0);
        check("rst_ports", {port_req_ready, port_wdata_ready, port_resp_valid}, 0);
        check("rst_rdata", port_resp_data, 0);
        port_req_valid = 0; port_req_write = 0; port_req_addr = '0; port_wdata = '0;
        reqack = 0; respcyc = 0; resp = '0;
        tick(); reset = 0; tick();

        // Port 0 read, address accepted on the second ADDR cycle.
        port_req_addr[63:0] = 64'h1000; port_req_valid = 2'b01;
        tick(); wait_reqcyc();
        port_req_valid = 0; reqack = 0; tick(); reqack = 1; tick(); reqack = 0;
        r = resp_cnt[0];
        for (int i = 0; i < BEATS; i++) begin
            respcyc = 1; resptag = 0; resp = 64'hA000 + 64'(i); tick();
        end
        respcyc = 0;
        check("t1_resp_pulses", resp_cnt[0] - r, 8);
        check("t1_tag", last_tag, 13'h0000);
        tick();
        check("t1_idle", reqcyc, 0);

        // Port 1 write burst, reqack held high throughout.
        port_req_addr[127:64] = 64'h2000; port_req_write = 2'b10; port_req_valid = 2'b10;
        reqack = 1; b = req_beats; wc = wrdy_cnt[1];
        tick(); port_req_valid = 0;
        for (int i = 0; i < 12; i++) begin
            port_wdata[127:64] = 64'hD000 + 64'(i); tick();
        end
        reqack = 0;
        check("t2_wdata_pulses", wrdy_cnt[1] - wc, 8);
        check("t2_req_beats", req_beats - b, 9);
        check("t2_tag", last_tag, 13'h1001);

        // Both ports requesting continuously.
        port_req_addr[63:0] = 64'h4000; port_req_addr[127:64] = 64'h5000;
        port_req_write = 2'b11; port_req_valid = 2'b11; reqack = 1;
        grants.delete(); n = 0;
        while (grants.size() < 4 && n < 200) begin tick(); n++; end
        check("t3_grant_count", grants.size(), 4);
        port_req_valid = 0; n = 0;
        while (reqcyc && n < 50) begin tick(); n++; end
        check("t3_drained", reqcyc, 0);
        reqack = 0; port_req_write = 0;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        exp_grants = '{0, 1, 0, 1};
`else
        exp_grants = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t3_grant_seq", grants[i], exp_grants[i]);
        tick();

        // Stray tag-1 beat during a port 0 read.
        port_req_addr[63:0] = 64'h6000; port_req_valid = 2'b01; reqack = 1;
        tick(); port_req_valid = 0; tick(); reqack = 0;
        r = resp_cnt[0]; a = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            respcyc = 1; resptag = (i == 3) ? 13'd1 : 13'd0; resp = 64'hB000 + 64'(i); tick();
        end
        check("t4_resp_pulses", resp_cnt[0] - r, 8);
        check("t4_acks", ack_cnt - a, 9);
        resptag = 0; tick(); respcyc = 0;
        check("t4_after_burst", resp_cnt[0] - r, 8);
        check("t4_idle_ack", ack_cnt - a, 10);

        // Reset in the middle of a read burst.
        port_req_addr[63:0] = 64'h7000; port_req_valid = 2'b01; reqack = 1;
        tick(); port_req_valid = 0; tick(); reqack = 0;
        for (int i = 0; i < 4; i++) begin
            respcyc = 1; resptag = 0; resp = 64'hC000 + 64'(i); tick();
        end
        resp = 64'hCAFE; r = resp_cnt[0];
        #2 reset = 1;
        #1;
        check("t5_reqcyc", reqcyc, 0);
        check("t5_respack", respack, 0);
        check("t5_resp_valid", port_resp_valid, 0);
        check("t5_rdata", port_resp_data, 0);
        check("t5_other_ports", {port_req_ready, port_wdata_ready}, 0);
        tick(); tick(); respcyc = 0; reset = 0; tick();
        check("t5_no_pulse", resp_cnt[0] - r, 0);
        check("t5_idle", reqcyc, 0);

        // Address beat held off for five cycles.
        port_req_addr[127:64] = 64'h3000; port_req_valid = 2'b10; reqack = 0;
        tick(); port_req_valid = 0; b = rdy_cnt[1];
        for (int i = 0; i < 5; i++) begin
            check("t6_req", req, 64'h3000);
            check("t6_tag", reqtag, 13'h0001);
            check("t6_no_ready", port_req_ready, 0);
            tick();
        end
        reqack = 1; tick(); reqack = 0;
        check("t6_ready_pulses", rdy_cnt[1] - b, 1);
        r = resp_cnt[1];
        for (int i = 0; i < BEATS; i++) begin
            respcyc = 1; resptag = 1; resp = 64'hE000 + 64'(i); tick();
        end
        respcyc = 0;
        check("t6_resp_pulses", resp_cnt[1] - r, 8);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
